// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staggered reset release sequencer driven by PLL lock
//
// Purpose: converts the raw PLL lock flag into NUM_CH synchronised, staggered
//   active-low resets, filtering lock glitches before any release.
// Optional feature macro: LOSS_CNT_EN (adds loss_count, a saturating lock-loss counter)
// Ports:
//   clk_48mhz   in   sole clock
//   nreset      in   asynchronous active-low reset
//   locked      in   raw PLL lock flag (asynchronous)
//   soft_rst    in   synchronous active-high re-sequence request
//   nrst_out    out  [NUM_CH-1:0] per-channel active-low resets, registered
//   ready       out  all channels released
//   state       out  [1:0] 0 WAIT_LOCK, 1 FILTER, 2 RELEASE, 3 RUN
//   loss_count  out  [7:0] lock losses from RELEASE/RUN (LOSS_CNT_EN only)
module reset_sequencer #(
   parameter int NUM_CH      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_FILTER = 16,
   parameter int HOLD_CYCLES = 8,
   parameter int STAGGER     = 4
) (
   input  logic              clk_48mhz,
   input  logic              nreset,
   input  logic              locked,
   input  logic              soft_rst,
   output logic [NUM_CH-1:0] nrst_out,
   output logic              ready,
   output logic [1:0]        state
`ifdef LOSS_CNT_EN
   ,
   output logic [7:0]        loss_count
`endif
);

   // Release time of the last channel; cnt must count up to this and to LOCK_FILTER-1.
   localparam int T_LAST  = HOLD_CYCLES + (NUM_CH - 1) * STAGGER;
   localparam int CNT_MAX = (LOCK_FILTER - 1 > T_LAST) ? LOCK_FILTER - 1 : T_LAST;
   localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      RELEASE   = 2'd2,
      RUN       = 2'd3
   } state_t;

   state_t                 state_q;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;

   assign lock_s = sync[SYNC_STAGES-1];
   assign state  = state_q;

   // Metastability synchroniser for the asynchronous lock flag.
   always_ff @(posedge clk_48mhz or negedge nreset) begin
      if (!nreset) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], locked};
      end
   end

   always_ff @(posedge clk_48mhz or negedge nreset) begin
      if (!nreset) begin
         state_q  <= WAIT_LOCK;
         cnt      <= '0;
         nrst_out <= '0;
         ready    <= 1'b0;
`ifdef LOSS_CNT_EN
         loss_count <= 8'd0;
`endif
      end else begin
         case (state_q)
            WAIT_LOCK: begin
               cnt      <= '0;
               nrst_out <= '0;
               ready    <= 1'b0;
               if (lock_s) begin
                  state_q <= FILTER;
               end
            end

            FILTER: begin
               if (!lock_s) begin
                  state_q <= WAIT_LOCK;
                  cnt     <= '0;
               end else if (cnt == CNT_W'(LOCK_FILTER - 1)) begin
                  state_q <= RELEASE;
                  cnt     <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end

            default: begin // RELEASE and RUN
               if (!lock_s) begin
                  // Lock loss outranks soft_rst.
                  state_q  <= WAIT_LOCK;
                  cnt      <= '0;
                  nrst_out <= '0;
                  ready    <= 1'b0;
`ifdef LOSS_CNT_EN
                  if (loss_count != 8'hFF) begin
                     loss_count <= loss_count + 8'd1;
                  end
`endif
               end else if (soft_rst) begin
                  // Re-run the stagger without repeating the lock filter.
                  state_q  <= RELEASE;
                  cnt      <= '0;
                  nrst_out <= '0;
                  ready    <= 1'b0;
               end else if (state_q == RUN) begin
                  nrst_out <= '1;
                  ready    <= 1'b1;
               end else begin
                  // Channels only ever rise here, so a released channel stays high.
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (cnt >= CNT_W'(HOLD_CYCLES + i * STAGGER)) begin
                        nrst_out[i] <= 1'b1;
                     end
                  end
                  if (cnt == CNT_W'(T_LAST)) begin
                     // Last channel rises on this same edge.
                     state_q <= RUN;
                     ready   <= 1'b1;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
